if_id_fetch_queue: RTL and testbench

- Small synchronous FIFO between the instruction-fetch stage and the decode stage.
- Buffers fetched instruction bundles {inst, pc, pc4} so a decode stall does not force fetch to stall immediately.
- Discards all buffered wrong-path instructions on a taken branch.
- Upstream producer is the IF stage output bundle; downstream consumer is the ID stage.

---
 rtl/if_id_fetch_queue.sv | 75 +++++++
 tb/tb_if_id_fetch_queue.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/if_id_fetch_queue.sv
// IF->ID fetch queue: small FIFO of {inst, pc, pc4} bundles that decouples a
// decode stall from fetch and drops every buffered wrong-path bundle on flush.
package if_stage_pkg;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } if_stage_out_t;
endpackage

module if_id_fetch_queue
  import if_stage_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [95:0]      in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [95:0]      out_data_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  if_stage_out_t    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, push, pop;

  assign full        = (count == CNT_W'(DEPTH));
  // No pass-through when full: a pop frees a slot only from the next cycle.
  assign in_ready_o  = !full && !flush_i;
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i && !flush_i;
  assign count_o     = count;
  assign out_data_o  = out_valid_o ? mem[rd_ptr] : '0;

  // Storage is not reset; out_data_o is masked while empty instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data_i;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!arst_n)
    count <= CNT_W'(DEPTH));
  a_empty_invalid: assert property (@(posedge clk) disable iff (!arst_n)
    (count == '0) |-> !out_valid_o);

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed table-driven bench for if_id_fetch_queue (DEPTH=4), plus a
// hand-written asynchronous-reset sequence.
module tb_if_id_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             arst_n;
  logic             flush_i, in_valid_i, in_ready_o;
  logic [95:0]      in_data_i, out_data_o;
  logic             out_valid_o, out_ready_i;
  logic [CNT_W-1:0] count_o;

  int tests = 0;
  int fails = 0;

  if_id_fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst_n(arst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    int          cnt;
    logic        ov;
    logic [31:0] opc;
    logic        ir;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [95:0] bundle(input logic [31:0] pc);
    return {32'h0000_0013, pc, pc + 32'd4};
  endfunction

  task automatic add(input logic fl, input logic iv, input logic [31:0] pc,
                     input logic ordy, input int cnt, input logic ov,
                     input logic [31:0] opc, input logic ir);
    vec_t v;
    v.flush = fl; v.iv = iv; v.pc = pc; v.ordy = ordy;
    v.cnt = cnt; v.ov = ov; v.opc = opc; v.ir = ir;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int cnt, input logic ov,
                            input logic [31:0] opc, input logic ir);
    check({tag, ".count"}, 96'(count_o), 96'(cnt));
    check({tag, ".out_valid"}, 96'(out_valid_o), 96'(ov));
    check({tag, ".out_data"}, out_data_o, ov ? bundle(opc) : 96'h0);
    check({tag, ".in_ready"}, 96'(in_ready_o), 96'(ir));
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] pc, input logic ordy);
    flush_i = fl; in_valid_i = iv; in_data_i = iv ? bundle(pc) : 96'h0; out_ready_i = ordy;
  endtask

  initial begin
    arst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);

    // fill 3 with no consumer
    add(0,1,32'h0,0, 0,0,32'h0,1);
    add(0,1,32'h4,0, 1,1,32'h0,1);
    add(0,1,32'h8,0, 2,1,32'h0,1);
    add(0,0,32'h0,0, 3,1,32'h0,1);
    // reach full, hold 0x10, single-cycle pop
    add(0,1,32'hC,0,  3,1,32'h0,1);
    add(0,1,32'h10,0, 4,1,32'h0,0);
    add(0,1,32'h10,1, 4,1,32'h0,0);
    add(0,1,32'h10,0, 3,1,32'h4,1);
    add(0,0,32'h0,0,  4,1,32'h4,0);
    // drain
    add(0,0,32'h0,1, 4,1,32'h4,0);
    add(0,0,32'h0,1, 3,1,32'h8,1);
    add(0,0,32'h0,1, 2,1,32'hC,1);
    add(0,0,32'h0,1, 1,1,32'h10,1);
    add(0,0,32'h0,0, 0,0,32'h0,1);
    // continuous stream 0x0..0x3C, pointers wrap
    for (int k = 0; k < 16; k++)
      add(0,1,32'(4*k),1, (k == 0) ? 0 : 1, k != 0, (k == 0) ? 32'h0 : 32'(4*(k-1)), 1);
    add(0,0,32'h0,1, 1,1,32'h3C,1);
    add(0,0,32'h0,0, 0,0,32'h0,1);
    // flush with 3 entries, then a fresh push
    add(0,1,32'h0,0,   0,0,32'h0,1);
    add(0,1,32'h4,0,   1,1,32'h0,1);
    add(0,1,32'h8,0,   2,1,32'h0,1);
    add(1,1,32'h100,0, 3,1,32'h0,0);
    add(0,1,32'h200,0, 0,0,32'h0,1);
    add(0,0,32'h0,1,   1,1,32'h200,1);
    add(0,0,32'h0,0,   0,0,32'h0,1);
    // flush while empty
    add(1,1,32'h300,0, 0,0,32'h0,0);
    add(0,0,32'h0,0,   0,0,32'h0,1);
    // empty queue, push with consumer ready: no bypass
    add(0,1,32'h40,1, 0,0,32'h0,1);
    add(0,0,32'h0,1,  1,1,32'h40,1);
    add(0,0,32'h0,0,  0,0,32'h0,1);

    #2;
    check_outs("reset", 0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    arst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].flush, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ov, vecs[i].opc, vecs[i].ir);
    end

    // asynchronous reset between edges with 2 entries held
    @(negedge clk); drive(0, 1'b1, 32'h500, 1'b0);
    @(negedge clk); drive(0, 1'b1, 32'h504, 1'b0);
    @(negedge clk); drive(0, 1'b0, 32'h0, 1'b0);
    #1;
    check_outs("pre_arst", 2, 1'b1, 32'h500, 1'b1);
    #1;
    arst_n = 1'b0;
    #1;
    check_outs("arst", 0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    check_outs("post_arst", 0, 1'b0, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
